// File: rtl/pe_double2int_pkg.sv
// Shared definitions for the binary64 -> int64 conversion PE: field widths,
// saturation constants, decoded-double and sideband types, and the input classifier.
package pe_double2int_pkg;

    localparam int dwidth_double = 64;
    localparam int DBL_BIAS      = 1023;
    localparam int DBL_EXP_W     = 11;
    localparam int DBL_FRAC_W    = 52;

    localparam logic [63:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic                  sign;
        logic [DBL_EXP_W-1:0]  expo;
        logic [DBL_FRAC_W-1:0] frac;
    } dbl_t;

    // Result category; decides the final mux in the last stage.
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_MIN  = 3'd2,
        CLS_SAT  = 3'd3,
        CLS_NAN  = 3'd4
    } cls_e;

    typedef struct packed {
        logic                     valid;
        logic                     conv;
        logic                     sign;
        cls_e                     cls;
        logic                     tiny_inx;
        logic [dwidth_double-1:0] raw;
    } side_t;

    function automatic cls_e dbl_classify(input dbl_t d);
        cls_e c;
        if (d.expo == 11'h7FF) begin
            if (d.frac == 52'd0) c = CLS_SAT;
            else                 c = CLS_NAN;
        end else if (d.expo < 11'd1023) begin
            c = CLS_ZERO;
        end else if (d.expo <= 11'd1085) begin
            c = CLS_NORM;
        end else if ((d.expo == 11'd1086) && d.sign && (d.frac == 52'd0)) begin
            c = CLS_MIN;
        end else begin
            c = CLS_SAT;
        end
        return c;
    endfunction

endpackage

// File: rtl/pe_double2int_dbl_shift_round.sv
// Two-stage mantissa aligner: picks shift direction/amount from the unbiased
// exponent, then barrel-shifts and reports whether any fraction bits were dropped.
module dbl_shift_round
    import pe_double2int_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [11:0]    k,
    input  logic [DBL_FRAC_W:0]   mant,
    output logic [63:0]           mag,
    output logic                  inexact
);

    logic                left_s, left_r;
    logic [5:0]          amt_s, amt_r;
    logic [DBL_FRAC_W:0] mask_s, mask_r, mant_r;
    logic [63:0]         ext_s, mag_s;
    logic                sticky_s;

    // Direction/amount decode; right shifts also build the mask of lost bits.
    always_comb begin
        left_s = 1'b0;
        amt_s  = 6'd0;
        mask_s = '0;
        if (k <= 12'sd52) begin
            amt_s  = 6'(12'sd52 - k);
            mask_s = (53'd1 << amt_s) - 53'd1;
        end else begin
            left_s = 1'b1;
            amt_s  = 6'(k - 12'sd52);
        end
    end

    // Shift-control register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_r <= 1'b0;
            amt_r  <= 6'd0;
            mask_r <= '0;
            mant_r <= '0;
        end else begin
            left_r <= left_s;
            amt_r  <= amt_s;
            mask_r <= mask_s;
            mant_r <= mant;
        end
    end

    // Barrel shift and sticky reduction.
    always_comb begin
        ext_s    = {11'd0, mant_r};
        mag_s    = 64'd0;
        sticky_s = |(mant_r & mask_r);
        if (left_r) mag_s = ext_s << amt_r;
        else        mag_s = ext_s >> amt_r;
    end

    // Magnitude/sticky register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag     <= 64'd0;
            inexact <= 1'b0;
        end else begin
            mag     <= mag_s;
            inexact <= sticky_s;
        end
    end

endmodule

// File: rtl/register_pipe.sv
// Generic clear-on-reset delay line; DEPTH=0 degenerates to a wire.
module register_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift register; every stage clears on reset so no stale valid survives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_double2int.sv
// Streaming binary64 -> int64 converter (round toward zero, saturating) with a
// matched-latency raw pass-through selected per word by op[0].
module pe_double2int #(
    parameter int dwidth_double = 64,
    parameter int latency       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [dwidth_double-1:0] inp1,
    input  logic                     t_valid_inp1,
    input  logic [1:0]               op,
    output logic [dwidth_double-1:0] out1,
    output logic                     t_valid_out1,
    output logic                     out_invalid,
    output logic                     out_inexact
);
    import pe_double2int_pkg::*;

    dbl_t                d_s;
    side_t               side1_s, side1_r, side2_r, side3_r;
    logic signed [11:0]  k_s, k1_r;
    logic [DBL_FRAC_W:0] mant1_r;
    logic [63:0]         mag_s, res_s, res_r;
    logic                sticky_s, inv_s, inx_s, inv_r, inx_r, valid_r;
    logic [66:0]         pipe_q_s;
    logic                unused_s;

    assign d_s      = inp1;
    assign unused_s = op[1];

    // Field decode and classification for stage 1.
    always_comb begin
        side1_s          = '0;
        side1_s.valid    = t_valid_inp1;
        side1_s.conv     = op[0];
        side1_s.sign     = d_s.sign;
        side1_s.cls      = dbl_classify(d_s);
        side1_s.tiny_inx = |inp1[62:0];
        side1_s.raw      = inp1;
        k_s              = $signed({1'b0, d_s.expo} - 12'(DBL_BIAS));
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side1_r <= '0;
            k1_r    <= 12'sd0;
            mant1_r <= '0;
        end else begin
            side1_r <= side1_s;
            k1_r    <= k_s;
            mant1_r <= {1'b1, d_s.frac};
        end
    end

    dbl_shift_round u_shift (
        .clk     (clk),
        .rst_n   (rst),
        .k       (k1_r),
        .mant    (mant1_r),
        .mag     (mag_s),
        .inexact (sticky_s)
    );

    // Sideband rides alongside the two shifter stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side2_r <= '0;
            side3_r <= '0;
        end else begin
            side2_r <= side1_r;
            side3_r <= side2_r;
        end
    end

    // Final result mux: negate, saturate, or forward the raw word.
    always_comb begin
        res_s = 64'd0;
        inv_s = 1'b0;
        inx_s = 1'b0;
        if (!side3_r.conv) begin
            res_s = side3_r.raw;
        end else begin
            case (side3_r.cls)
                CLS_NORM: begin
                    res_s = side3_r.sign ? (64'd0 - mag_s) : mag_s;
                    inx_s = sticky_s;
                end
                CLS_ZERO: inx_s = side3_r.tiny_inx;
                CLS_MIN:  res_s = INT64_MIN;
                CLS_SAT: begin
                    res_s = side3_r.sign ? INT64_MIN : INT64_MAX;
                    inv_s = 1'b1;
                end
                CLS_NAN:  inv_s = 1'b1;
                default: begin
                    res_s = 64'd0;
                    inv_s = 1'b0;
                    inx_s = 1'b0;
                end
            endcase
        end
    end

    // Stage 4 output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
            res_r   <= 64'd0;
            inv_r   <= 1'b0;
            inx_r   <= 1'b0;
        end else begin
            valid_r <= side3_r.valid;
            res_r   <= res_s;
            inv_r   <= inv_s;
            inx_r   <= inx_s;
        end
    end

    register_pipe #(
        .WIDTH (67),
        .DEPTH (latency - 4)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst),
        .d     ({valid_r, inv_r, inx_r, res_r}),
        .q     (pipe_q_s)
    );

    assign t_valid_out1 = pipe_q_s[66];
    assign out_invalid  = pipe_q_s[65];
    assign out_inexact  = pipe_q_s[64];
    assign out1         = pipe_q_s[63:0];

endmodule

// File: tb/tb_pe_double2int.sv
// Scoreboard bench for pe_double2int at latency 4 and 6, both fed the same stream.
module tb_pe_double2int;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] inp1;
    logic        t_valid_inp1;
    logic [1:0]  op;
    logic [63:0] o4, o6;
    logic        v4, v6, inv4, inv6, inx4, inx6;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [63:0] d;
        logic        inv;
        logic        inx;
    } exp_t;

    exp_t q4[$];
    exp_t q6[$];
    exp_t e4, e6;

    localparam logic [63:0] MAXI = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINI = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_double2int #(.dwidth_double(64), .latency(4)) dut4 (
        .clk(clk), .rst(rst), .inp1(inp1), .t_valid_inp1(t_valid_inp1), .op(op),
        .out1(o4), .t_valid_out1(v4), .out_invalid(inv4), .out_inexact(inx4)
    );

    pe_double2int #(.dwidth_double(64), .latency(6)) dut6 (
        .clk(clk), .rst(rst), .inp1(inp1), .t_valid_inp1(t_valid_inp1), .op(op),
        .out1(o6), .t_valid_out1(v6), .out_invalid(inv6), .out_inexact(inx6)
    );

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Independent reference: widen the mantissa and take integer/fraction slices.
    task automatic model(input logic [1:0] o, input logic [63:0] x,
                         output logic [63:0] d, output logic inv, output logic inx);
        logic [127:0] w;
        logic [63:0]  m;
        int           e;
        d = 64'd0; inv = 1'b0; inx = 1'b0;
        e = int'(x[62:52]);
        if (!o[0]) begin
            d = x;
        end else if (e == 2047) begin
            inv = 1'b1;
            if (x[51:0] == 52'd0) d = x[63] ? MINI : MAXI;
        end else if (e < 1023) begin
            inx = (x[62:0] != 63'd0);
        end else if (e >= 1086) begin
            if (x[63] && e == 1086 && x[51:0] == 52'd0) begin
                d = MINI;
            end else begin
                inv = 1'b1;
                d = x[63] ? MINI : MAXI;
            end
        end else begin
            w   = {75'd0, 1'b1, x[51:0]} << (e - 1023);
            m   = w[115:52];
            inx = |w[51:0];
            d   = x[63] ? (64'd0 - m) : m;
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [63:0] x,
                         input logic [63:0] rd, input logic ri, input logic rx);
        exp_t e;
        op = o; inp1 = x; t_valid_inp1 = 1'b1;
        e.d = rd; e.inv = ri; e.inx = rx;
        e.due = cyc + 4; q4.push_back(e);
        e.due = cyc + 6; q6.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic send_m(input logic [1:0] o, input logic [63:0] x);
        logic [63:0] d;
        logic        inv, inx;
        model(o, x, d, inv, inx);
        drive(o, x, d, inv, inx);
    endtask

    task automatic idle();
        t_valid_inp1 = 1'b0;
        inp1 = {$urandom, $urandom};
        op = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
    endtask

    // Output monitor: every cycle either a due entry matches or valid must be low.
    always @(negedge clk) begin
        if (q4.size() > 0 && q4[0].due == cyc) begin
            e4 = q4.pop_front();
            cmp("valid_l4", 64'(v4), 64'd1);
            cmp("out1_l4", o4, e4.d);
            cmp("invalid_l4", 64'(inv4), 64'(e4.inv));
            cmp("inexact_l4", 64'(inx4), 64'(e4.inx));
        end else begin
            cmp("idle_l4", 64'(v4), 64'd0);
        end
        if (q6.size() > 0 && q6[0].due == cyc) begin
            e6 = q6.pop_front();
            cmp("valid_l6", 64'(v6), 64'd1);
            cmp("out1_l6", o6, e6.d);
            cmp("invalid_l6", 64'(inv6), 64'(e6.inv));
            cmp("inexact_l6", 64'(inx6), 64'(e6.inx));
        end else begin
            cmp("idle_l6", 64'(v6), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] o;
        int         n;
        rst = 1'b0; t_valid_inp1 = 1'b0; inp1 = 64'd0; op = 2'd0;
        #1;
        cmp("rst_out1_l4", o4, 64'd0);
        cmp("rst_flags_l4", 64'({v4, inv4, inx4}), 64'd0);
        cmp("rst_out1_l6", o6, 64'd0);
        cmp("rst_flags_l6", 64'({v6, inv6, inx6}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed conversions and pass-through.
        drive(2'b01, 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        drive(2'b01, 64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
        drive(2'b01, 64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
        drive(2'b01, 64'h43E0_0000_0000_0000, MAXI, 1'b1, 1'b0);
        drive(2'b01, 64'hC3E0_0000_0000_0000, MINI, 1'b0, 1'b0);
        drive(2'b01, 64'h7FF8_0000_0000_0000, 64'd0, 1'b1, 1'b0);
        drive(2'b01, 64'hFFF0_0000_0000_0000, MINI, 1'b1, 1'b0);
        drive(2'b11, 64'h3FF8_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1);
        drive(2'b00, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
        drive(2'b10, 64'h7FF8_0000_0000_0001, 64'h7FF8_0000_0000_0001, 1'b0, 1'b0);
        drive(2'b01, 64'h0000_0000_0000_0001, 64'd0, 1'b0, 1'b1);
        drive(2'b01, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0);
        drive(2'b01, 64'h43D0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        drive(2'b01, 64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0);
        drive(2'b01, 64'hC3E0_0000_0000_0001, MINI, 1'b1, 1'b0);
        drive(2'b01, 64'h4330_0000_0000_0000, 64'h0010_0000_0000_0000, 1'b0, 1'b0);
        repeat (8) idle();

        // Mixed-op stream with a bubble every third cycle.
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 2) begin
                idle();
            end else begin
                o = (n % 2 == 0) ? 2'b00 : 2'b01;
                if (n == 0)
                    send_m(o, 64'hDEAD_BEEF_0123_4567);
                else if (o == 2'b00)
                    send_m(o, {$urandom, $urandom});
                else
                    send_m(o, {1'($urandom_range(0, 1)), 11'($urandom_range(1000, 1090)),
                               20'($urandom), $urandom});
                n++;
            end
        end
        repeat (8) idle();

        // Reset with three words in flight; they must vanish.
        send_m(2'b01, 64'h4000_0000_0000_0000);
        send_m(2'b00, 64'h1234_5678_9ABC_DEF0);
        send_m(2'b01, 64'hC000_0000_0000_0000);
        rst = 1'b0; t_valid_inp1 = 1'b0;
        q4.delete(); q6.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) idle();
        drive(2'b01, 64'h4059_0000_0000_0000, 64'h0000_0000_0000_0064, 1'b0, 1'b0);
        repeat (8) idle();

        cmp("drained_l4", 64'(q4.size()), 64'd0);
        cmp("drained_l6", 64'(q6.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_double2int.md
Name: pe_double2int

Overview:
- Double-precision PE that converts IEEE-754 binary64 to signed 64-bit integer. It is the return path of the existing int64-to-double PE.
- Selected by op[0]=1. With op[0]=0 the input passes through unchanged on a matched-latency delay line.
- The conversion is implemented in RTL (no vendor IP) so the team controls rounding and saturation.
- Fully pipelined, valid-only streaming (no backpressure). Accepts one word per cycle.

Parameters:
- dwidth_double, 64, data width. Only 64 is supported.
- latency, 4, input-to-output latency in cycles. Must be ≥4. Stages beyond 4 are pure output delay.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- inp1  input  64  operand: binary64 (op[0]=1) or raw word (op[0]=0)
- t_valid_inp1  input  1  inp1/op qualifier
- op  input  2  op[0]: 1 = convert, 0 = pass-through. op[1] is reserved and ignored.
- out1  output  64  int64 result or delayed raw word
- t_valid_out1  output  1  out1 qualifier
- out_invalid  output  1  NaN, Inf or out-of-range input; meaningful only when t_valid_out1=1
- out_inexact  output  1  nonzero fraction discarded; meaningful only when t_valid_out1=1

Behaviour:
- Reset (rst=0, asynchronous): every pipeline register clears to 0, including all valid bits. Outputs read 0 until the first valid word emerges.
- Sampling: inp1 and op are sampled together when t_valid_inp1=1. Each word carries its own op, so mixed op streams are legal back-to-back.
- Latency: out1 appears exactly `latency` cycles after the input is sampled. t_valid_out1 is asserted for exactly that cycle.
- Bubbles: an invalid input cycle produces t_valid_out1=0 `latency` cycles later. out1 is don't-care in that cycle.
- Pass-through (op[0]=0): out1 = inp1 bit-exact. out_invalid=0, out_inexact=0.
- Conversion field decode: s = inp1[63], e = inp1[62:52], f = inp1[51:0], k = e − 1023 (signed 12-bit).
- Rounding: round toward zero (C cast semantics).
- Case e=0 (zero or subnormal): result 0. inexact = (f≠0).
- Case 1≤e≤1022 (|x|<1): result 0, inexact=1.
- Case 0≤k≤62: magnitude M = {1,f} >> (52−k) when k≤52, else {1,f} << (k−52). inexact = any bits shifted out are nonzero. Result = s ? −M : M (two's complement).
- Case k=63, s=1, f=0 (exactly −2^63): result 0x8000_0000_0000_0000. No flags.
- Case k≥63, any other non-special value: saturate to 0x7FFF_FFFF_FFFF_FFFF if s=0, 0x8000_0000_0000_0000 if s=1. invalid=1.
- Case e=2047, f=0 (±Inf): saturate by sign as above. invalid=1.
- Case e=2047, f≠0 (NaN): result 0, invalid=1. When invalid=1, inexact=0.
- Mandatory pipeline stages:
  - S1: register fields; classify special/zero/small/normal; compute k.
  - S2: compute shift direction and amount (6 bits); register the inexact mask.
  - S3: 64-bit barrel shift; OR-reduce discarded bits.
  - S4: conditional negate and saturation mux; register outputs.
- The pass-through word and op bit ride a parallel delay alongside S1–S4.
- Reset mid-stream: in-flight words are dropped. No spurious valid is output after reset deasserts. The first output is the first word sampled after release.

Decomposition:
- Shared package holds: dwidth_double; DBL_BIAS=1023; DBL_EXP_W=11; DBL_FRAC_W=52; INT64_MAX/INT64_MIN constants; and a typedef struct for the decoded double (sign, exp, frac).
- Reuse the existing register_pipe for the (latency−4) output delay.
- One natural sub-module: dbl_shift_round. It performs the S2–S3 shift plus sticky/inexact computation and is reusable by a future double-to-int32 PE.

Test Plan:
- 0x3FF0_0000_0000_0000 (1.0), op=1 → out1=0x0000_0000_0000_0001 after 4 cycles, flags 0,0.
- 0xC004_0000_0000_0000 (−2.5) → 0xFFFF_FFFF_FFFF_FFFE, inexact=1. Then 0x3FE0_0000_0000_0000 (0.5) → 0, inexact=1.
- 0x43E0_0000_0000_0000 (2^63) → 0x7FFF_FFFF_FFFF_FFFF, invalid=1. Then 0xC3E0_0000_0000_0000 (−2^63) → 0x8000_0000_0000_0000, flags 0.
- 0x7FF8_0000_0000_0000 (NaN) → 0, invalid=1. Then 0xFFF0_0000_0000_0000 (−Inf) → 0x8000_0000_0000_0000, invalid=1.
- Back-to-back stream with alternating op (0,1,0,1) and a bubble every third cycle → output order, values and valid pattern match a reference model cycle for cycle. Pass-through words are bit-exact, e.g. 0xDEAD_BEEF_0123_4567.
- Assert rst=0 for one cycle while 3 words are in flight → t_valid_out1=0 for the next 4 cycles. A fresh input of 0x4059_0000_0000_0000 (100.0) returns 0x64 four cycles after sampling. Repeat with latency=6: the same word returns 0x64 after 6 cycles.
